wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_if.sv | 35 +++
 rtl/wb_arbiter.sv | 133 +++++++++++++
 tb/tb_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bundle: ALU result port, load result port,
// register-file write port, and status.
interface wb_arbiter_if #(
  parameter int LBUF_DEPTH = 4,
  parameter int DATA_W     = 32
);
  localparam int CNT_W = $clog2(LBUF_DEPTH) + 1;

  logic              alu_valid;
  logic              alu_ready;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [4:0]        ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic [4:0]        rf_wp;
  logic [DATA_W-1:0] rf_din;
  logic              rf_we;
  logic              drop_err;
  logic              drop_clr;
  logic [CNT_W-1:0]  pending;

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, drop_clr,
    output alu_ready, ld_ready, rf_wp, rf_din, rf_we, drop_err, pending
  );

  // Producer / register-file side.
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data, drop_clr,
    input  alu_ready, ld_ready, rf_wp, rf_din, rf_we, drop_err, pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges ALU results and buffered load results into the
// single register-file write port, keeping per-destination write order and
// dropping writes to illegal destinations.
module wb_arbiter #(
  parameter int LBUF_DEPTH = 4,
  parameter int DATA_W     = 32
) (
  input  logic        clk,
  input  logic        rstn,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(LBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(LBUF_DEPTH);

  // Load buffer storage (no reset: validity is tracked in r_vld).
  logic [4:0]            r_rd_mem   [LBUF_DEPTH];
  logic [DATA_W-1:0]     r_data_mem [LBUF_DEPTH];
  logic [LBUF_DEPTH-1:0] r_vld;
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;

  // Registered write port and sticky error.
  logic [4:0]            r_wp;
  logic [DATA_W-1:0]     r_din;
  logic                  r_we;
  logic                  r_drop_err;

  logic [LBUF_DEPTH-1:0] w_match;
  logic [LBUF_DEPTH-1:0] w_vld_next;
  logic w_haz, w_full, w_empty;
  logic w_ld_rdy, w_alu_rdy;
  logic w_alu_acc, w_ld_acc;
  logic w_alu_legal, w_ld_legal;
  logic w_wr_alu, w_pop, w_push, w_drop;

  // rd 0 is the zero register and 15 is the core-ID register; 21..31 unmapped.
  function automatic logic legal_rd(input logic [4:0] rd);
    return (rd != 5'd0) && (rd <= 5'd20) && (rd != 5'd15);
  endfunction

  // An ALU write must not overtake any buffered load to the same register.
  genvar gi;
  generate
    for (gi = 0; gi < LBUF_DEPTH; gi++) begin : g_match
      assign w_match[gi] = r_vld[gi] && (r_rd_mem[gi] == bus.alu_rd);
    end
  endgenerate

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_haz       = |w_match;
  assign w_ld_rdy    = rstn && !w_full;
  assign w_alu_rdy   = w_ld_rdy && !w_haz;
  assign w_alu_acc   = bus.alu_valid && w_alu_rdy;
  assign w_ld_acc    = bus.ld_valid && w_ld_rdy;
  assign w_alu_legal = legal_rd(bus.alu_rd);
  assign w_ld_legal  = legal_rd(bus.ld_rd);

  // A full buffer never accepts the ALU, so "pop unless a legal ALU write
  // owns the port" covers both the full-buffer and plain-drain priorities.
  assign w_wr_alu = w_alu_acc && w_alu_legal;
  assign w_pop    = !w_empty && !w_wr_alu;
  assign w_push   = w_ld_acc && w_ld_legal;
  assign w_drop   = (w_alu_acc && !w_alu_legal) || (w_ld_acc && !w_ld_legal);

  // Next entry-valid mask: clear the popped head, set the pushed tail.
  always_comb begin
    w_vld_next = r_vld;
    if (w_pop)  w_vld_next[r_head] = 1'b0;
    if (w_push) w_vld_next[r_tail] = 1'b1;
  end

  // Load buffer payload write.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_tail]   <= bus.ld_rd;
      r_data_mem[r_tail] <= bus.ld_data;
    end
  end

  // Buffer pointers, occupancy and entry-valid mask.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      r_vld   <= w_vld_next;
    end
  end

  // Register-file write port; index 0 on idle so the file does not clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_din <= '0;
      r_we  <= 1'b0;
    end else if (w_wr_alu) begin
      r_wp  <= bus.alu_rd;
      r_din <= bus.alu_data;
      r_we  <= 1'b1;
    end else if (w_pop) begin
      r_wp  <= r_rd_mem[r_head];
      r_din <= r_data_mem[r_head];
      r_we  <= 1'b1;
    end else begin
      r_wp  <= '0;
      r_din <= '0;
      r_we  <= 1'b0;
    end
  end

  // Sticky drop flag; a new drop beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)             r_drop_err <= 1'b0;
    else if (w_drop)       r_drop_err <= 1'b1;
    else if (bus.drop_clr) r_drop_err <= 1'b0;
  end

  assign bus.alu_ready = w_alu_rdy;
  assign bus.ld_ready  = w_ld_rdy;
  assign bus.rf_wp     = r_wp;
  assign bus.rf_din    = r_din;
  assign bus.rf_we     = r_we;
  assign bus.drop_err  = r_drop_err;
  assign bus.pending   = r_count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.LBUF_DEPTH(DEPTH), .DATA_W(DW)) bus ();

  wb_arbiter #(.LBUF_DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: pending loads in arrival order, expected outputs.
  logic [4:0]    mq_rd   [$];
  logic [DW-1:0] mq_data [$];
  logic [4:0]    e_wp;
  logic [DW-1:0] e_din;
  logic          e_we;
  logic          e_drop;

  // Log of writes observed at the DUT write port.
  logic [4:0]    wlog_rd   [$];
  logic [DW-1:0] wlog_data [$];
  int            max_pend = 0;

  logic [4:0]    t3_rd   [9] = '{5'd6, 5'd6, 5'd6, 5'd6, 5'd1, 5'd6, 5'd2, 5'd4, 5'd5};
  logic [DW-1:0] t3_data [9] = '{32'h60, 32'h61, 32'h62, 32'h63, 32'h101,
                                 32'h64, 32'h102, 32'h104, 32'h105};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  function automatic logic legal(input logic [4:0] rd);
    return (rd >= 5'd1) && (rd <= 5'd20) && (rd != 5'd15);
  endfunction

  // Every falling edge: compare DUT against the model, then advance the
  // model with the inputs that the next rising edge will sample.
  always @(negedge clk) begin
    logic full_m, haz_m, alu_acc, ld_acc, drop_m;
    if (!rstn) begin
      mq_rd.delete();
      mq_data.delete();
      e_wp = '0; e_din = '0; e_we = 1'b0; e_drop = 1'b0;
      chk("rst_rf_we",     64'(bus.rf_we),     64'(0));
      chk("rst_rf_wp",     64'(bus.rf_wp),     64'(0));
      chk("rst_pending",   64'(bus.pending),   64'(0));
      chk("rst_alu_ready", 64'(bus.alu_ready), 64'(0));
      chk("rst_ld_ready",  64'(bus.ld_ready),  64'(0));
    end else begin
      full_m = (mq_rd.size() == DEPTH);
      haz_m  = 1'b0;
      foreach (mq_rd[k]) if (mq_rd[k] == bus.alu_rd) haz_m = 1'b1;

      chk("rf_wp",     64'(bus.rf_wp),     64'(e_wp));
      chk("rf_din",    64'(bus.rf_din),    64'(e_din));
      chk("rf_we",     64'(bus.rf_we),     64'(e_we));
      chk("pending",   64'(bus.pending),   64'(mq_rd.size()));
      chk("drop_err",  64'(bus.drop_err),  64'(e_drop));
      chk("alu_ready", 64'(bus.alu_ready), 64'(!full_m && !haz_m));
      chk("ld_ready",  64'(bus.ld_ready),  64'(!full_m));

      if (bus.rf_we) begin
        wlog_rd.push_back(bus.rf_wp);
        wlog_data.push_back(bus.rf_din);
      end
      if (int'(bus.pending) > max_pend) max_pend = int'(bus.pending);

      alu_acc = bus.alu_valid && !full_m && !haz_m;
      ld_acc  = bus.ld_valid && !full_m;
      drop_m  = 1'b0;
      if (full_m) begin
        e_wp = mq_rd.pop_front(); e_din = mq_data.pop_front(); e_we = 1'b1;
      end else if (alu_acc && legal(bus.alu_rd)) begin
        e_wp = bus.alu_rd; e_din = bus.alu_data; e_we = 1'b1;
      end else begin
        if (alu_acc) drop_m = 1'b1;
        if (mq_rd.size() > 0) begin
          e_wp = mq_rd.pop_front(); e_din = mq_data.pop_front(); e_we = 1'b1;
        end else begin
          e_wp = '0; e_din = '0; e_we = 1'b0;
        end
      end
      if (ld_acc) begin
        if (legal(bus.ld_rd)) begin
          mq_rd.push_back(bus.ld_rd);
          mq_data.push_back(bus.ld_data);
        end else begin
          drop_m = 1'b1;
        end
      end
      if (drop_m) e_drop = 1'b1;
      else if (bus.drop_clr) e_drop = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [DW-1:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] rd, input logic [DW-1:0] d);
    bus.ld_valid = v; bus.ld_rd = rd; bus.ld_data = d;
  endtask

  initial begin
    int base;
    set_alu(1'b0, 5'd0, '0);
    set_ld(1'b0, 5'd0, '0);
    bus.drop_clr = 1'b0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Idle after reset.
    repeat (10) cyc();
    chk("idle_pending",   64'(bus.pending),   64'(0));
    chk("idle_alu_ready", 64'(bus.alu_ready), 64'(1));
    chk("idle_ld_ready",  64'(bus.ld_ready),  64'(1));
    chk("idle_rf_we",     64'(bus.rf_we),     64'(0));

    // Single ALU write.
    set_alu(1'b1, 5'd3, 32'hA5A5_0001);
    cyc();
    set_alu(1'b0, 5'd0, '0);
    #1;
    chk("alu1_wp",  64'(bus.rf_wp),  64'(3));
    chk("alu1_din", 64'(bus.rf_din), 64'h0000_0000_A5A5_0001);
    chk("alu1_we",  64'(bus.rf_we),  64'(1));
    cyc();
    chk("alu1_idle_we", 64'(bus.rf_we), 64'(0));
    chk("alu1_idle_wp", 64'(bus.rf_wp), 64'(0));

    // Fill the buffer while the ALU keeps the port busy.
    base = wlog_rd.size();
    max_pend = 0;
    for (int c = 0; c < 4; c++) begin
      set_ld(1'b1, t3_rd[4 + (c == 0 ? 0 : c + 1 + (c == 3 ? 0 : 0)) - (c == 0 ? 0 : 0)], '0);
      case (c)
        0: set_ld(1'b1, 5'd1, 32'h101);
        1: set_ld(1'b1, 5'd2, 32'h102);
        2: set_ld(1'b1, 5'd4, 32'h104);
        default: set_ld(1'b1, 5'd5, 32'h105);
      endcase
      set_alu(1'b1, 5'd6, 32'h60 + DW'(c));
      cyc();
    end
    set_ld(1'b0, 5'd0, '0);
    set_alu(1'b1, 5'd6, 32'h64);
    #1;
    chk("full_pending",   64'(bus.pending),   64'(4));
    chk("full_alu_ready", 64'(bus.alu_ready), 64'(0));
    chk("full_ld_ready",  64'(bus.ld_ready),  64'(0));
    cyc();
    cyc();
    set_alu(1'b0, 5'd0, '0);
    repeat (6) cyc();
    chk("full_max_pend", 64'(max_pend), 64'(4));
    chk("full_nwrites",  64'(wlog_rd.size() - base), 64'(9));
    if (wlog_rd.size() - base == 9) begin
      for (int i = 0; i < 9; i++) begin
        chk("full_order_rd",   64'(wlog_rd[base + i]),   64'(t3_rd[i]));
        chk("full_order_data", 64'(wlog_data[base + i]), 64'(t3_data[i]));
      end
    end

    // Write-after-write hazard on rd 7.
    base = wlog_rd.size();
    set_ld(1'b1, 5'd7, 32'h11);
    cyc();
    set_ld(1'b0, 5'd0, '0);
    set_alu(1'b1, 5'd7, 32'h22);
    #1;
    chk("haz_stall", 64'(bus.alu_ready), 64'(0));
    cyc();
    chk("haz_release", 64'(bus.alu_ready), 64'(1));
    cyc();
    set_alu(1'b0, 5'd0, '0);
    repeat (3) cyc();
    chk("haz_nwrites", 64'(wlog_rd.size() - base), 64'(2));
    if (wlog_rd.size() - base == 2) begin
      chk("haz_first",  64'(wlog_data[base]),     64'h11);
      chk("haz_second", 64'(wlog_data[base + 1]), 64'h22);
    end

    // Illegal destinations and drop flag.
    base = wlog_rd.size();
    set_alu(1'b1, 5'd15, 32'h33);
    cyc();
    set_alu(1'b0, 5'd0, '0);
    set_ld(1'b1, 5'd0, 32'h44);
    cyc();
    set_ld(1'b1, 5'd25, 32'h55);
    cyc();
    set_ld(1'b0, 5'd0, '0);
    repeat (3) cyc();
    chk("ill_drop_err", 64'(bus.drop_err), 64'(1));
    chk("ill_no_write", 64'(wlog_rd.size() - base), 64'(0));
    bus.drop_clr = 1'b1;
    cyc();
    bus.drop_clr = 1'b0;
    chk("clr_alone", 64'(bus.drop_err), 64'(0));
    bus.drop_clr = 1'b1;
    set_ld(1'b1, 5'd21, 32'h66);
    cyc();
    bus.drop_clr = 1'b0;
    set_ld(1'b0, 5'd0, '0);
    chk("clr_vs_drop", 64'(bus.drop_err), 64'(1));
    bus.drop_clr = 1'b1;
    cyc();
    bus.drop_clr = 1'b0;

    // Asynchronous reset with three loads buffered.
    set_ld(1'b1, 5'd1, 32'hB1); set_alu(1'b1, 5'd6, 32'hC0); cyc();
    set_ld(1'b1, 5'd2, 32'hB2); set_alu(1'b1, 5'd6, 32'hC1); cyc();
    set_ld(1'b1, 5'd4, 32'hB4); set_alu(1'b1, 5'd6, 32'hC2); cyc();
    set_ld(1'b0, 5'd0, '0); set_alu(1'b0, 5'd0, '0);
    chk("pre_rst_pending", 64'(bus.pending), 64'(3));
    #1 rstn = 1'b0;
    #1;
    chk("arst_rf_we",     64'(bus.rf_we),     64'(0));
    chk("arst_rf_wp",     64'(bus.rf_wp),     64'(0));
    chk("arst_rf_din",    64'(bus.rf_din),    64'(0));
    chk("arst_pending",   64'(bus.pending),   64'(0));
    chk("arst_alu_ready", 64'(bus.alu_ready), 64'(0));
    chk("arst_ld_ready",  64'(bus.ld_ready),  64'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    base = wlog_rd.size();
    repeat (5) cyc();
    chk("post_rst_no_write", 64'(wlog_rd.size() - base), 64'(0));
    chk("post_rst_pending",  64'(bus.pending), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
